divider: RTL and testbench

Sequential signed fixed-point divider for the ODE accelerator's arithmetic unit. It is the inverse operation to the multiplier and shares its handshake (`start` / `finish`, `result`, `overflow_flag`), so the datapath controller can issue either operation identically. It computes `A / B` in two's-complement Q(W-1-F).F format, using restoring division with one quotient bit per cycle. The result saturates on overflow and on divide-by-zero.

---
 rtl/divider_pkg.sv | 29 ++
 rtl/divider_fx_saturate.sv | 58 +++++
 rtl/divider.sv | 141 ++++++++++++++
 tb/tb_divider.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : divider_pkg
//  Description : Shared fixed-point definitions for the arithmetic unit:
//                default operand format, saturation constants and the
//                operation-controller state encoding used by both the
//                multiplier and the divider.
//  Revision    : 1.0  initial release
// ============================================================================
package divider_pkg;

  // Default format is Q5.10: 1.0 == 16'h0400
  localparam int DEFAULT_WIDTH     = 16;
  localparam int DEFAULT_FRAC_BITS = 10;

  // Saturation limits for the default width
  localparam logic [DEFAULT_WIDTH-1:0] FX_MAX = 16'h7FFF;
  localparam logic [DEFAULT_WIDTH-1:0] FX_MIN = 16'h8000;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } fx_state_t;

endpackage : divider_pkg
`default_nettype wire

// File: rtl/divider_fx_saturate.sv
`default_nettype none
// ============================================================================
//  Module      : fx_saturate
//  Description : Combinational sign application and saturation of an
//                unsigned quotient/product magnitude to a signed WIDTH-bit
//                fixed-point result.
//  Ports       : sign     - result is negative
//                q        - unsigned magnitude (Q_WIDTH bits)
//                divzero  - force saturation by the sign of the dividend
//                result   - signed, saturated WIDTH-bit value
//                overflow - set when the result saturated
//  Revision    : 1.0  initial release
// ============================================================================
module fx_saturate
  import divider_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int Q_WIDTH = DEFAULT_WIDTH + DEFAULT_FRAC_BITS
) (
  input  logic               sign,
  input  logic [Q_WIDTH-1:0] q,
  input  logic               divzero,
  output logic [WIDTH-1:0]   result,
  output logic               overflow
);

  localparam logic [WIDTH-1:0]   C_MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   C_MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  // Largest magnitudes representable as positive / negative results
  localparam logic [Q_WIDTH-1:0] C_POS_LIM = {{(Q_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [Q_WIDTH-1:0] C_NEG_LIM = {{(Q_WIDTH-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] w_q_low;
  logic [WIDTH-1:0] w_q_neg;

  assign w_q_low = q[WIDTH-1:0];
  assign w_q_neg = -w_q_low;

  always_comb begin
    result   = w_q_low;
    overflow = 1'b0;
    if (divzero) begin
      // With B == 0 the sign flag equals the dividend sign
      result   = sign ? C_MIN_VAL : C_MAX_VAL;
      overflow = 1'b1;
    end else if (!sign && (q > C_POS_LIM)) begin
      result   = C_MAX_VAL;
      overflow = 1'b1;
    end else if (sign && (q > C_NEG_LIM)) begin
      result   = C_MIN_VAL;
      overflow = 1'b1;
    end else if (sign) begin
      result   = w_q_neg;
    end
  end

endmodule : fx_saturate
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// ============================================================================
//  Module      : divider
//  Description : Sequential signed fixed-point divider, restoring algorithm,
//                one quotient bit per cycle. Result truncates toward zero and
//                saturates on overflow and divide-by-zero.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                A, B            - dividend / divisor, sampled on accept
//                start           - request, acted on at its rising edge
//                result          - quotient (held until next completion)
//                overflow_flag   - result saturated or B was zero
//                finish          - high while outputs hold a completed op
//  Revision    : 1.0  initial release
// ============================================================================
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int FRAC_BITS = DEFAULT_FRAC_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             overflow_flag,
  output logic             finish
);

  localparam int               C_Q_WIDTH   = WIDTH + FRAC_BITS;
  localparam int               C_CNT_W     = $clog2(C_Q_WIDTH);
  localparam logic [C_CNT_W-1:0] C_LAST_ITER = C_CNT_W'(C_Q_WIDTH - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);

  fx_state_t              r_state;
  fx_state_t              w_state_next;
  logic                   r_start_q;
  logic                   r_sign;
  logic                   r_divzero;
  logic [WIDTH-1:0]       r_mag_b;
  logic [WIDTH:0]         r_rem;
  // Shifts dividend bits out of the top while quotient bits enter the bottom;
  // after the last iteration it holds the quotient magnitude.
  logic [C_Q_WIDTH-1:0]   r_dvd;
  logic [C_CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]       r_result;
  logic                   r_ovf;
  logic                   r_finish;

  logic                   w_accept;
  logic [WIDTH-1:0]       w_mag_a;
  logic [WIDTH+1:0]       w_rem_shift;
  logic [WIDTH:0]         w_diff;
  logic                   w_fits;
  logic [WIDTH-1:0]       w_sat_result;
  logic                   w_sat_ovf;

  // Requests are only taken when no operation is in flight
  assign w_accept = start & ~r_start_q & ((r_state == ST_IDLE) | (r_state == ST_DONE));

  // 0x8000 maps to magnitude 32768, which fits as unsigned
  assign w_mag_a = A[WIDTH-1] ? -A : A;

  assign w_rem_shift = {r_rem, r_dvd[C_Q_WIDTH-1]};
  assign w_fits      = (w_rem_shift >= {2'b00, r_mag_b});
  assign w_diff      = w_rem_shift[WIDTH:0] - {1'b0, r_mag_b};

  fx_saturate #(
    .WIDTH   (WIDTH),
    .Q_WIDTH (C_Q_WIDTH)
  ) u_sat (
    .sign     (r_sign),
    .q        (r_dvd),
    .divzero  (r_divzero),
    .result   (w_sat_result),
    .overflow (w_sat_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_CALC;
      ST_CALC: if (r_cnt == C_LAST_ITER) w_state_next = ST_FIX;
      ST_FIX:  w_state_next = ST_DONE;
      ST_DONE: if (w_accept) w_state_next = ST_CALC;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_q <= 1'b0;
      r_sign    <= 1'b0;
      r_divzero <= 1'b0;
      r_mag_b   <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
      r_finish  <= 1'b0;
    end else begin
      r_start_q <= start;
      if (w_accept) begin
        r_sign    <= A[WIDTH-1] ^ B[WIDTH-1];
        r_divzero <= (B == '0);
        r_mag_b   <= B[WIDTH-1] ? -B : B;
        r_rem     <= '0;
        r_dvd     <= {w_mag_a, {FRAC_BITS{1'b0}}};
        r_cnt     <= '0;
        r_finish  <= 1'b0;
      end else begin
        case (r_state)
          ST_CALC: begin
            r_rem <= w_fits ? w_diff : w_rem_shift[WIDTH:0];
            r_dvd <= {r_dvd[C_Q_WIDTH-2:0], w_fits};
            r_cnt <= r_cnt + C_CNT_ONE;
          end
          ST_FIX: begin
            r_result <= w_sat_result;
            r_ovf    <= w_sat_ovf;
            r_finish <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign result        = r_result;
  assign overflow_flag = r_ovf;
  assign finish        = r_finish;

endmodule : divider
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider
//  Description : Self-checking bench for the Q5.10 divider. A transaction
//                level model predicts finish/result/overflow_flag every
//                cycle; directed operations also carry literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic        start;
  logic [15:0] result;
  logic        overflow_flag;
  logic        finish;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  divider dut (
    .clk           (clk),
    .rst           (rst),
    .A             (A),
    .B             (B),
    .start         (start),
    .result        (result),
    .overflow_flag (overflow_flag),
    .finish        (finish)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact signed arithmetic on the Q5.10 values. Returns {ovf, result}.
  function automatic logic [16:0] model_div(input logic [15:0] a, input logic [15:0] b);
    longint sa, sb, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) return {1'b1, (sa >= 0) ? 16'h7FFF : 16'h8000};
    q = (sa * 1024) / sb;   // SV integer division truncates toward zero
    if (q > 32767)  return {1'b1, 16'h7FFF};
    if (q < -32768) return {1'b1, 16'h8000};
    return {1'b0, q[15:0]};
  endfunction

  // Cycle model: an accepted request completes 27 edges later
  logic        m_prev, m_busy, m_fin, m_ovf, p_ovf;
  logic [15:0] m_res, p_res;
  int          m_cnt;

  always @(posedge clk) begin
    logic [16:0] pr;
    if (rst) begin
      m_prev <= 1'b0; m_busy <= 1'b0; m_fin <= 1'b0;
      m_res  <= '0;   m_ovf  <= 1'b0; m_cnt <= 0;
    end else begin
      m_prev <= start;
      if (m_busy) begin
        if (m_cnt == 1) begin
          m_res  <= p_res;
          m_ovf  <= p_ovf;
          m_fin  <= 1'b1;
          m_busy <= 1'b0;
        end
        m_cnt <= m_cnt - 1;
      end else if (start && !m_prev) begin
        pr = model_div(A, B);
        p_res  <= pr[15:0];
        p_ovf  <= pr[16];
        m_busy <= 1'b1;
        m_cnt  <= 27;
        m_fin  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_finish", {31'b0, finish}, {31'b0, m_fin});
      check("cyc_result", {16'b0, result}, {16'b0, m_res});
      check("cyc_ovf", {31'b0, overflow_flag}, {31'b0, m_ovf});
    end
  end

  // Called at E0 + #2; returns edges until finish observed (40 = timeout)
  task automatic wait_finish(output int n);
    n = 0;
    while (!finish && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_out(input string nm, input int n, input logic [15:0] er, input logic eo);
    check({nm, "_lat"}, n, 27);
    check({nm, "_res"}, {16'b0, result}, {16'b0, er});
    check({nm, "_ovf"}, {31'b0, overflow_flag}, {31'b0, eo});
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic eo, input string nm);
    int n;
    check({nm, "_model"}, {15'b0, model_div(a, b)}, {15'b0, eo, er});
    @(posedge clk); #2;
    A = a; B = b; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_finish(n);
    check_out(nm, n, er, eo);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        o;
    string       nm;
  } vec_t;

  vec_t vecs[10] = '{
    '{16'h0C00, 16'h0800, 16'h0600, 1'b0, "pos"},
    '{16'hF400, 16'h0800, 16'hFA00, 1'b0, "neg"},
    '{16'h0400, 16'h0C00, 16'h0155, 1'b0, "trunc_pos"},
    '{16'hFC00, 16'h0C00, 16'hFEAB, 1'b0, "trunc_neg"},
    '{16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, "sat_max"},
    '{16'h8000, 16'hFC00, 16'h7FFF, 1'b1, "min_div_m1"},
    '{16'h8000, 16'h0400, 16'h8000, 1'b0, "min_div_1"},
    '{16'h8000, 16'h0000, 16'h8000, 1'b1, "dz_neg"},
    '{16'h0000, 16'h0000, 16'h7FFF, 1'b1, "dz_zero"},
    '{16'h0400, 16'h0000, 16'h7FFF, 1'b1, "dz_pos"}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rises;
    logic prev_fin;

    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    check("rst_result", {16'b0, result}, 32'h0);
    check("rst_ovf", {31'b0, overflow_flag}, 32'h0);
    check("rst_finish", {31'b0, finish}, 32'h0);
    #1 rst = 1'b0;

    foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].o, vecs[i].nm);

    // start held high for 40 cycles: one operation only
    @(posedge clk); #2;
    A = 16'hF400; B = 16'h0800; start = 1'b1;
    rises = 0; prev_fin = finish;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (finish && !prev_fin) rises++;
      prev_fin = finish;
    end
    check("held_rises", rises, 1);
    check("held_finish", {31'b0, finish}, 32'h1);
    check("held_res", {16'b0, result}, 32'hFA00);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("held_finish_after", {31'b0, finish}, 32'h1);

    // start pulse during CALC is ignored
    @(posedge clk); #2;
    A = 16'h0400; B = 16'h0C00; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; A = 16'h0C00; B = 16'h0800;
    n = 0;
    while (!finish && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 5) start = 1'b1;
      if (n == 6) start = 1'b0;
    end
    check_out("calc_pulse", n, 16'h0155, 1'b0);
    repeat (30) @(posedge clk);
    #1 check("calc_pulse_no_queue", {31'b0, finish}, 32'h1);
    check("calc_pulse_hold", {16'b0, result}, 32'h0155);

    // back-to-back start from DONE clears finish at the accepting edge
    @(posedge clk); #2;
    A = 16'hF400; B = 16'h0800; start = 1'b1;
    @(posedge clk); #1;
    check("b2b_clear", {31'b0, finish}, 32'h0);
    check("b2b_old_res", {16'b0, result}, 32'h0155);
    #1 start = 1'b0;
    wait_finish(n);
    check_out("b2b", n, 16'hFA00, 1'b0);

    // reset at iteration 10 abandons the operation
    @(posedge clk); #2;
    A = 16'h7FFF; B = 16'h0001; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_result", {16'b0, result}, 32'h0);
    check("midrst_ovf", {31'b0, overflow_flag}, 32'h0);
    check("midrst_finish", {31'b0, finish}, 32'h0);
    #1 rst = 1'b0;
    do_op(16'h0C00, 16'h0800, 16'h0600, 1'b0, "after_rst");

    // start held across reset is seen as a fresh request
    @(posedge clk); #2;
    rst = 1'b1; start = 1'b1; A = 16'hFC00; B = 16'h0C00;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    wait_finish(n);
    check_out("start_over_rst", n, 16'hFEAB, 1'b0);
    start = 1'b0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_divider
`default_nettype wire
